// File: rtl/sprite_frame_sequencer.sv
// Per-frame sprite scheduler. Once per frame it erases every enabled client,
// pulses update, then draws every enabled client. It owns the single VGA plot
// port and muxes the active client's pixel stream onto it.
module sprite_frame_sequencer #(
  parameter int N_CLIENTS   = 4,
  parameter int FRAME_TICKS = 833334,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CLIENTS-1:0]   client_en,
  input  logic [9*N_CLIENTS-1:0] client_x,
  input  logic [8*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0] client_colour,
  input  logic [N_CLIENTS-1:0]   client_done,
  output logic [N_CLIENTS-1:0]   erase_req,
  output logic [N_CLIENTS-1:0]   draw_req,
  output logic                   update,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IDX_W = $clog2(N_CLIENTS + 1);
  localparam int FC_W  = $clog2(FRAME_TICKS);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    E_REQ,
    E_WAIT,
    UPD,
    D_REQ,
    D_WAIT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nx;
  logic [FC_W-1:0]    frame_cnt;
  logic [TO_W-1:0]    wait_cnt;
  logic               tick;
  logic               in_wait;
  logic               done_seen;
  logic               to_hit;
  logic               advance;
  logic               last_slot;

  logic               sel_en;
  logic               sel_done;
  logic [8:0]         sel_x;
  logic [7:0]         sel_y;
  logic [2:0]         sel_colour;
  logic [N_CLIENTS-1:0] slot_onehot;

  assign tick      = (frame_cnt == FC_LAST);
  assign busy      = (state != IDLE);
  assign in_wait   = (state == E_WAIT) || (state == D_WAIT);
  assign last_slot = (idx == LAST_IDX);

  // The first WAIT cycle (wait_cnt == 0) ignores done to cover client FSM
  // latency; a timeout advances the slot exactly as a done would.
  assign done_seen = in_wait && (wait_cnt != '0) && sel_done;
  assign to_hit    = in_wait && (wait_cnt == TO_LAST) && !done_seen;
  assign advance   = done_seen || to_hit;

  // Select the active client's enable, done and pixel data by slot index.
  always_comb begin
    sel_en      = 1'b0;
    sel_done    = 1'b0;
    sel_x       = '0;
    sel_y       = '0;
    sel_colour  = '0;
    slot_onehot = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_en         = client_en[i];
        sel_done       = client_done[i];
        sel_x          = client_x[9*i +: 9];
        sel_y          = client_y[8*i +: 8];
        sel_colour     = client_colour[3*i +: 3];
        slot_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and request pulse decode for the erase/update/draw sequence.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    erase_req = '0;
    draw_req  = '0;
    update    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nx = E_REQ;
          idx_nx   = '0;
        end
      end
      E_REQ: begin
        if (sel_en) begin
          erase_req = slot_onehot;
          state_nx  = E_WAIT;
        end else if (last_slot) begin
          state_nx = UPD;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      E_WAIT: begin
        if (advance) begin
          if (last_slot) begin
            state_nx = UPD;
            idx_nx   = '0;
          end else begin
            state_nx = E_REQ;
            idx_nx   = idx + IDX_W'(1);
          end
        end
      end
      UPD: begin
        update   = 1'b1;
        idx_nx   = '0;
        state_nx = D_REQ;
      end
      D_REQ: begin
        if (sel_en) begin
          draw_req = slot_onehot;
          state_nx = D_WAIT;
        end else if (last_slot) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      D_WAIT: begin
        if (advance) begin
          if (last_slot) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            state_nx = D_REQ;
            idx_nx   = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // State and slot index registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Free-running frame counter; tick is its terminal count.
  always_ff @(posedge clk) begin
    if (!reset || tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  // WAIT-cycle counter, zero on the first cycle of every WAIT visit.
  always_ff @(posedge clk) begin
    if (!reset || !in_wait) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Registered VGA port: plot follows WAIT cycles except the one that ends
  // the slot, and pixel data only moves when a plot is being issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (in_wait && !advance) begin
      vga_x      <= sel_x;
      vga_y      <= sel_y;
      vga_colour <= sel_colour;
      vga_plot   <= 1'b1;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

  // Sticky error flags; a tick outside IDLE (including the last D_WAIT
  // cycle) is dropped and recorded as an overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
